// File: rtl/cook_sequencer.sv
// Microwave control and timekeeping core: keypad entry into an M:SS BCD time
// register, cook/pause/done sequencing, and a per-second countdown with display blanking.
module cook_sequencer #(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic       mag_on,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic [2:0] blank_digits,
    output logic [1:0] state,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    min_q, min_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          startn_q, stopn_q;
    logic [9:0]    keypad_q;

    logic          start_press, stop_press, key_press;
    logic [3:0]    key_digit;
    logic          time_zero;
    logic [11:0]   dec_val;

    // Borrow chain across the three BCD digits; seconds roll over to 59.
    function automatic logic [11:0] dec_time(input logic [3:0] m,
                                             input logic [3:0] t,
                                             input logic [3:0] o);
        if (o != 4'd0)
            return {m, t, o - 4'd1};
        else if (t != 4'd0)
            return {m, t - 4'd1, 4'd9};
        else
            return {m - 4'd1, 4'd5, 4'd9};
    endfunction

    assign start_press = startn_q & ~startn;
    assign stop_press  = stopn_q & ~stopn;
    assign key_press   = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0)
                         && (keypad_q == 10'd0);
    assign time_zero   = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign dec_val     = dec_time(min_q, tens_q, ones_q);

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_digit = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (!clearn) begin
            state_d = IDLE;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else begin
            unique case (state_q)
                COOK: begin
                    if (!door_closed || stop_press) begin
                        state_d = PAUSE;
                    end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
                        presc_d = '0;
                        {min_d, tens_d, ones_d} = dec_val;
                        if (dec_val == 12'd0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                DONE: begin
                    if (!door_closed) begin
                        state_d = IDLE;
                    end else if (stop_press) begin
                        state_d = IDLE;
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                    end else if (key_press) begin
                        // Entry after a finished cook starts from a fresh 0:00.
                        state_d = IDLE;
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        ones_d  = key_digit;
                    end
                end
                PAUSE: begin
                    if (stop_press) begin
                        state_d = IDLE;
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                    end else if (start_press && door_closed && !time_zero) begin
                        state_d = COOK;
                        presc_d = '0;
                    end
                end
                default: begin
                    if (start_press && door_closed && !time_zero) begin
                        state_d = COOK;
                        presc_d = '0;
                    end else if (key_press) begin
                        min_d  = tens_q;
                        tens_d = ones_q;
                        ones_d = key_digit;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            min_q    <= 4'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            presc_q  <= '0;
            done_q   <= 1'b0;
            startn_q <= startn;
            stopn_q  <= stopn;
            keypad_q <= keypad;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
            startn_q <= startn;
            stopn_q  <= stopn;
            keypad_q <= keypad;
        end
    end

    assign mag_on       = (state_q == COOK);
    assign min_bcd      = min_q;
    assign sec_tens_bcd = tens_q;
    assign sec_ones_bcd = ones_q;
    assign blank_digits = {min_q == 4'd0, (min_q == 4'd0) && (tens_q == 4'd0), 1'b0};
    assign state        = state_q;
    assign done         = done_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed front-panel scenarios plus random panel
// activity, all compared every cycle against a seconds-level reference model.
module tb_cook_sequencer;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keypad;
    logic       startn, stopn, clearn, door_closed;
    logic       mag_on, done;
    logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
    logic [2:0] blank_digits;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Reference model: time held as a plain number MSS (e.g. 125 = 1:25).
    int m_st, m_t, m_ps, m_done;
    int m_startn_prev, m_stopn_prev, m_kp_prev;

    cook_sequencer #(.TICKS_PER_SEC(T)) dut (
        .clock(clock), .reset(reset), .keypad(keypad), .startn(startn),
        .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .mag_on(mag_on), .min_bcd(min_bcd), .sec_tens_bcd(sec_tens_bcd),
        .sec_ones_bcd(sec_ones_bcd), .blank_digits(blank_digits),
        .state(state), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit sp, tp, kp;
        int kd, ones_cnt;
        m_done = 0;
        if (reset) begin
            m_st = 0; m_t = 0; m_ps = 0;
        end else begin
            sp = (m_startn_prev == 0) ? 1'b0 : 1'b0;
            sp = (m_stopn_prev == 1) && (stopn == 1'b0);
            tp = (m_startn_prev == 1) && (startn == 1'b0);
            ones_cnt = 0; kd = 0;
            for (int i = 0; i < 10; i++) if (keypad[i]) begin ones_cnt++; kd = i; end
            kp = (ones_cnt == 1) && (m_kp_prev == 0);
            if (!clearn) begin
                m_st = 0; m_t = 0;
            end else if (m_st == 1 && !door_closed) m_st = 2;
            else if (m_st == 3 && !door_closed) m_st = 0;
            else if (sp && m_st == 1) m_st = 2;
            else if (sp && (m_st == 2 || m_st == 3)) begin m_st = 0; m_t = 0; end
            else if (tp && (m_st == 0 || m_st == 2) && door_closed && m_t != 0) begin
                m_st = 1; m_ps = 0;
            end else if (kp && (m_st == 0 || m_st == 3)) begin
                if (m_st == 3) m_t = 0;
                m_t = (m_t % 100) * 10 + kd;
                m_st = 0;
            end else if (m_st == 1) begin
                if (m_ps == T - 1) begin
                    m_ps = 0;
                    m_t = (m_t % 100 == 0) ? m_t - 41 : m_t - 1;
                    if (m_t == 0) begin m_st = 3; m_done = 1; end
                end else m_ps++;
            end
        end
        m_startn_prev = startn;
        m_stopn_prev  = stopn;
        m_kp_prev     = keypad;
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        chk("state", state, m_st);
        chk("mag_on", mag_on, m_st == 1);
        chk("done", done, m_done);
        chk("min", min_bcd, m_t / 100);
        chk("tens", sec_tens_bcd, (m_t / 10) % 10);
        chk("ones", sec_ones_bcd, m_t % 10);
        chk("blank", blank_digits, {m_t < 100, m_t < 10, 1'b0});
    endtask

    task automatic press_key(input int d);
        keypad = 10'(1 << d); step();
        keypad = 10'd0;       step();
    endtask

    task automatic press_start();
        startn = 1'b0; step();
        startn = 1'b1; step();
    endtask

    task automatic press_stop();
        stopn = 1'b0; step();
        stopn = 1'b1; step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int n;
    int r;

    initial begin
        reset = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1;
        clearn = 1'b1; door_closed = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(1);
        chk("rst_blank", blank_digits, 3'b110);

        // Digit entry 1,2,5 then 7.
        press_key(1); press_key(2); press_key(5);
        chk("entry_val", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h125);
        chk("entry_blank", blank_digits, 3'b000);
        press_key(7);
        chk("entry_shift", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h257);

        // Full cook of 1:25.
        clearn = 1'b0; step(); clearn = 1'b1; step();
        press_key(1); press_key(2); press_key(5);
        startn = 1'b0; step();
        chk("start_mag", mag_on, 1);
        startn = 1'b1;
        n = 0;
        do begin
            step(); n++;
            if (n == 4) chk("first_dec", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h124);
        end while (!done && n < 400);
        chk("done_cycle", n, 340);
        chk("done_time", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h000);
        step();
        chk("done_pulse", done, 0);
        chk("end_blank", blank_digits, 3'b110);

        // Pause/resume at 0:10.
        press_key(1); press_key(0);
        startn = 1'b0; step(); startn = 1'b1;
        idle_cycles(8);
        stopn = 1'b0; step(); stopn = 1'b1;
        chk("pause_state", state, 2);
        chk("pause_time", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h008);
        idle_cycles(20);
        chk("frozen", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h008);
        startn = 1'b0; step(); startn = 1'b1;
        idle_cycles(4);
        chk("resume_dec", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h007);
        press_stop(); press_stop();
        chk("stop_idle", state, 0);

        // Door handling.
        press_key(3); press_start();
        door_closed = 1'b0; step();
        chk("door_pause", mag_on, 0);
        press_start();
        chk("door_start_ign", state, 2);
        door_closed = 1'b1; step();
        press_start();
        chk("door_resume", state, 1);

        // Clear mid-cook, start at zero, multi-hot, held key.
        clearn = 1'b0; step(); clearn = 1'b1;
        chk("clear_idle", state, 0);
        press_start();
        chk("zero_start", state, 0);
        keypad = 10'b0000000011; step(); keypad = 10'd0; step();
        chk("multihot", sec_ones_bcd, 0);
        keypad = 10'(1 << 3); idle_cycles(10); keypad = 10'd0; step();
        chk("held_key", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h003);

        // Stop and start together in COOK, then reset mid-cook.
        press_start();
        startn = 1'b0; stopn = 1'b0; step(); startn = 1'b1; stopn = 1'b1;
        chk("stop_start", state, 2);
        press_start();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid", {state, mag_on, done, blank_digits}, {2'd0, 1'b0, 1'b0, 3'b110});
        step();

        // Random panel activity.
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 9);
            keypad = (r < 6) ? 10'd0 : (r < 9) ? 10'(1 << $urandom_range(0, 9))
                                              : 10'($urandom);
            startn = ($urandom_range(0, 7) != 0);
            stopn  = ($urandom_range(0, 24) != 0);
            clearn = ($urandom_range(0, 149) != 0);
            door_closed = ($urandom_range(0, 29) != 0);
            reset  = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
